posit_encoder: RTL and testbench

Pipelined posit encoder: packs a decoded posit (sign, signed regime, exponent, extended fraction, sticky) into a WIDTH-bit posit word, with round-to-nearest-even and saturation to maxpos/minpos. It is the output end of the posit datapath: arithmetic units consume decoder fields and hand their results to this block for re-encoding. The block has two stages and a valid/ready handshake on both sides.

---
 rtl/posit_pkg.sv | 43 ++++
 rtl/posit_round.sv | 25 ++
 rtl/posit_encoder.sv | 134 +++++++++++++
 tb/tb_posit_encoder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit types, sizing constants and special-value helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package posit_pkg;

    localparam int POSIT_WIDTH = 8;
    localparam int POSIT_EXP   = 2;
    // Widest fraction that can appear in a word, and signed regime width.
    localparam int MTS  = POSIT_WIDTH - 3 - POSIT_EXP;
    localparam int REGI = $clog2(POSIT_WIDTH) + 1;

    typedef enum logic [1:0] {
        PCLS_NORM = 2'd0,
        PCLS_ZERO = 2'd1,
        PCLS_NAR  = 2'd2
    } pcls_t;

    // Largest positive posit: 0 followed by w-1 ones.
    function automatic logic [31:0] posit_maxpos(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Smallest positive posit: 0...01.
    function automatic logic [31:0] posit_minpos(input int w);
        return (w > 1) ? 32'd1 : 32'd0;
    endfunction

    // NaR: 1 followed by w-1 zeros.
    function automatic logic [31:0] posit_nar(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // NaR dominates zero; anything else is a normal value.
    function automatic pcls_t get_vld(input logic nar, input logic zero);
        if (nar)
            return PCLS_NAR;
        else if (zero)
            return PCLS_ZERO;
        else
            return PCLS_NORM;
    endfunction

endpackage

// File: rtl/posit_round.sv
// Round-to-nearest-even on a posit magnitude, saturating at maxpos.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: m_i magnitude (MW bits), g_i guard bit, s_i sticky OR,
//        m_o rounded magnitude. RND_EN=0 turns it into a pass-through.
module posit_round #(
    parameter int MW     = 7,
    parameter bit RND_EN = 1'b1
) (
    input  logic [MW-1:0] m_i,
    input  logic          g_i,
    input  logic          s_i,
    output logic [MW-1:0] m_o
);

    logic          inc;
    logic [MW:0]   sum;

    assign inc = RND_EN & g_i & (s_i | m_i[0]);
    assign sum = {1'b0, m_i} + {{MW{1'b0}}, inc};
    // A carry out only happens from all-ones, i.e. maxpos: stay there
    // instead of wrapping into the NaR pattern.
    assign m_o = sum[MW] ? {MW{1'b1}} : sum[MW-1:0];

endmodule

// File: rtl/posit_encoder.sv
// Packs decoded posit fields into a WIDTH-bit word with RNE rounding and saturation.
// Latency: 2 cycles from accept to vld_o; 1 result per cycle.
// Backpressure: valid/ready both sides; output holds while stalled, rdy_o drops only when both stages are full.
// Ports: clk_i, rst (sync, active-high); vld_i/rdy_o with sign_i, regi_i (signed k),
//        exp_i, frac_i, sticky_i, zero_i, nar_i; pout/vld_o/rdy_i on the output.
// Build option: POSIT_ENC_ROUND_EN selects round-to-nearest-even; without it, truncation.
module posit_encoder
    import posit_pkg::*;
#(
    parameter int WIDTH = POSIT_WIDTH,
    parameter int EXP   = POSIT_EXP,
    parameter int FRAC  = WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   vld_i,
    output logic                   rdy_o,
    input  logic                   sign_i,
    input  logic [$clog2(WIDTH):0] regi_i,
    input  logic [EXP-1:0]         exp_i,
    input  logic [FRAC-1:0]        frac_i,
    input  logic                   sticky_i,
    input  logic                   zero_i,
    input  logic                   nar_i,
    output logic [WIDTH-1:0]       pout,
    output logic                   vld_o,
    input  logic                   rdy_i
);

    localparam int MW = WIDTH - 1;          // magnitude width
    localparam int TW = EXP + FRAC + 1;     // exp + frac + sticky
    localparam int BW = WIDTH + TW;         // body: longest regime (WIDTH bits) + tail

    localparam logic [WIDTH-1:0] MAXPOS = WIDTH'(posit_maxpos(WIDTH));
    localparam logic [WIDTH-1:0] MINPOS = WIDTH'(posit_minpos(WIDTH));
    localparam logic [WIDTH-1:0] NARW   = WIDTH'(posit_nar(WIDTH));

`ifdef POSIT_ENC_ROUND_EN
    localparam bit RND_EN = 1'b1;
`else
    localparam bit RND_EN = 1'b0;
`endif

    logic          v1, v2;
    logic          ld1, ld2;
    pcls_t         cls1;
    logic          sign1;
    logic [BW-1:0] body1;
    logic [BW-1:0] body_c;
    logic [TW-1:0] tail;
    int            k;

    // Stage 2 loads when empty or draining; stage 1 when empty or advancing.
    assign ld2   = v1 & (~v2 | rdy_i);
    assign rdy_o = ~v2 | rdy_i | ~v1;
    assign ld1   = vld_i & rdy_o;
    assign vld_o = v2;

    assign tail = {exp_i, frac_i, sticky_i};

    // Left-aligned body. Out-of-range k is replaced by a body whose top
    // bits are maxpos/minpos with nothing below, so rounding leaves it alone.
    always_comb begin
        k      = int'($signed(regi_i));
        body_c = '0;
        if (k > WIDTH - 2)
            body_c = {MAXPOS[MW-1:0], {(TW + 1){1'b0}}};
        else if (k < -(WIDTH - 2))
            body_c = {MINPOS[MW-1:0], {(TW + 1){1'b0}}};
        else if (k >= 0)
            // k+1 ones, terminating 0, then the tail
            body_c = ~({BW{1'b1}} >> (k + 1)) | ({tail, {WIDTH{1'b0}}} >> (k + 2));
        else
            // -k zeros, terminating 1, then the tail
            body_c = ({1'b1, {(BW - 1){1'b0}}} >> (-k)) | ({tail, {WIDTH{1'b0}}} >> (1 - k));
    end

    logic [MW-1:0]    m_s2, m_fin;
    logic             g_s2, s_s2;
    logic [WIDTH-1:0] mag, p_c;

    assign m_s2 = body1[BW-1 -: MW];
    assign g_s2 = body1[BW-MW-1];
    assign s_s2 = |body1[BW-MW-2:0];

    posit_round #(
        .MW     (MW),
        .RND_EN (RND_EN)
    ) u_round (
        .m_i (m_s2),
        .g_i (g_s2),
        .s_i (s_s2),
        .m_o (m_fin)
    );

    assign mag = {1'b0, m_fin};

    always_comb begin
        p_c = mag;
        case (cls1)
            PCLS_NAR:  p_c = NARW;
            PCLS_ZERO: p_c = '0;
            default:   p_c = sign1 ? (~mag + WIDTH'(1)) : mag;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            cls1  <= PCLS_ZERO;
            sign1 <= 1'b0;
            body1 <= '0;
            pout  <= '0;
        end else begin
            if (ld1) begin
                v1    <= 1'b1;
                cls1  <= get_vld(nar_i, zero_i);
                sign1 <= sign_i;
                body1 <= body_c;
            end else if (ld2) begin
                v1 <= 1'b0;
            end

            if (ld2) begin
                v2   <= 1'b1;
                pout <= p_c;
            end else if (rdy_i) begin
                v2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_posit_encoder.sv
// Self-checking bench for posit_encoder (WIDTH=8, EXP=2, FRAC=8).
// Latency: expects results 2 cycles after accept.
// Backpressure: exercises stalls, toggling rdy_i and reset with data in flight.
module tb_posit_encoder;

`ifdef POSIT_ENC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        bit       sign;
        int       k;
        bit [1:0] e;
        bit [7:0] f;
        bit       st;
        bit       zero;
        bit       nar;
    } item_t;

    logic       clk_i = 1'b0;
    logic       rst = 1'b1;
    logic       vld_i = 1'b0;
    logic       rdy_o;
    logic       sign_i = 1'b0;
    logic [3:0] regi_i = '0;
    logic [1:0] exp_i = '0;
    logic [7:0] frac_i = '0;
    logic       sticky_i = 1'b0;
    logic       zero_i = 1'b0;
    logic       nar_i = 1'b0;
    logic [7:0] pout;
    logic       vld_o;
    logic       rdy_i = 1'b0;

    int checks = 0;
    int errors = 0;

    posit_encoder #(.WIDTH(8), .EXP(2), .FRAC(8)) dut (
        .clk_i    (clk_i),
        .rst      (rst),
        .vld_i    (vld_i),
        .rdy_o    (rdy_o),
        .sign_i   (sign_i),
        .regi_i   (regi_i),
        .exp_i    (exp_i),
        .frac_i   (frac_i),
        .sticky_i (sticky_i),
        .zero_i   (zero_i),
        .nar_i    (nar_i),
        .pout     (pout),
        .vld_o    (vld_o),
        .rdy_i    (rdy_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: write out the posit bit string (regime run, exp, frac,
    // sticky), read the first 7 bits as magnitude, then guard and sticky.
    function automatic logic [7:0] model(input item_t it);
        bit q[$];
        int mag;
        bit g, s;
        if (it.nar) return 8'h80;
        if (it.zero) return 8'h00;
        if (it.k > 6) mag = 127;
        else if (it.k < -6) mag = 1;
        else begin
            if (it.k >= 0) begin
                for (int i = 0; i <= it.k; i++) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                for (int i = 0; i < -it.k; i++) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = 1; i >= 0; i--) q.push_back(it.e[i]);
            for (int i = 7; i >= 0; i--) q.push_back(it.f[i]);
            q.push_back(it.st);
            while (q.size() < 9) q.push_back(1'b0);
            mag = 0;
            for (int i = 0; i < 7; i++) mag = mag * 2 + int'(q[i]);
            g = q[7];
            s = 1'b0;
            for (int i = 8; i < q.size(); i++) s |= q[i];
            if (ROUND && g && (s || (mag % 2 == 1))) mag++;
            if (mag > 127) mag = 127;
        end
        return it.sign ? 8'((256 - mag) % 256) : 8'(mag);
    endfunction

    function automatic item_t mk(input bit sg, input int k, input bit [1:0] e,
                                 input bit [7:0] f, input bit st, input bit z, input bit n);
        item_t it;
        it.sign = sg; it.k = k; it.e = e; it.f = f; it.st = st; it.zero = z; it.nar = n;
        return it;
    endfunction

    function automatic item_t rand_item();
        item_t it;
        it.sign = 1'($urandom);
        it.k    = int'($urandom_range(0, 15)) - 8;
        it.e    = 2'($urandom);
        it.f    = 8'($urandom);
        it.st   = 1'($urandom);
        it.zero = ($urandom % 16) == 0;
        it.nar  = ($urandom % 16) == 0;
        return it;
    endfunction

    task automatic drive(input item_t it);
        sign_i   = it.sign;
        regi_i   = 4'(it.k);
        exp_i    = it.e;
        frac_i   = it.f;
        sticky_i = it.st;
        zero_i   = it.zero;
        nar_i    = it.nar;
    endtask

    // Sends one item into an empty pipe and reports the result and the
    // number of cycles from presentation until vld_o (10 = timed out).
    task automatic run_one(input item_t it, output logic [7:0] p, output int lat);
        @(negedge clk_i);
        drive(it);
        vld_i = 1'b1;
        rdy_i = 1'b1;
        @(posedge clk_i);
        lat = 1;
        @(negedge clk_i);
        vld_i = 1'b0;
        while (!vld_o && lat < 10) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        p = pout;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld_i = 1'b0;
        rdy_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst = 1'b0;
        checks++;
        if (vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld_o got %b want 0", vld_o); end
        checks++;
        if (pout !== 8'h00) begin errors++; $display("FAIL reset_pout got %h want 00", pout); end
        checks++;
        if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy_o got %b want 1", rdy_o); end
    endtask

    task automatic test_exact();
        item_t      its[3];
        logic [7:0] want[3];
        logic [7:0] p;
        int         lat;
        its[0] = mk(0, 0, 2'd0, 8'h00, 0, 0, 0); want[0] = 8'h40;
        its[1] = mk(0, 0, 2'd0, 8'h80, 0, 0, 0); want[1] = 8'h44;
        its[2] = mk(1, 0, 2'd0, 8'h00, 0, 0, 0); want[2] = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            run_one(its[i], p, lat);
            checks++;
            if (p !== want[i]) begin errors++; $display("FAIL exact[%0d] got %h want %h", i, p, want[i]); end
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL latency[%0d] got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_clamp();
        item_t      its[6];
        logic [7:0] want[6];
        logic [7:0] p;
        int         lat;
        its[0] = mk(0, 6, 2'd0, 8'h00, 0, 0, 0);  want[0] = 8'h7F;
        its[1] = mk(0, 7, 2'd3, 8'hFF, 1, 0, 0);  want[1] = 8'h7F;
        its[2] = mk(0, -6, 2'd0, 8'h00, 0, 0, 0); want[2] = 8'h01;
        its[3] = mk(0, -7, 2'd0, 8'h00, 0, 0, 0); want[3] = 8'h01;
        its[4] = mk(0, 6, 2'd3, 8'hFF, 1, 0, 0);  want[4] = 8'h7F;
        its[5] = mk(1, -8, 2'd0, 8'h00, 0, 0, 0); want[5] = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            run_one(its[i], p, lat);
            checks++;
            if (p !== want[i]) begin errors++; $display("FAIL clamp[%0d] got %h want %h", i, p, want[i]); end
        end
    endtask

    task automatic test_round();
        item_t      its[4];
        logic [7:0] want[4];
        logic [7:0] p;
        int         lat;
        its[0] = mk(0, 0, 2'd0, 8'b0001_1000, 0, 0, 0); want[0] = ROUND ? 8'h41 : 8'h40;
        its[1] = mk(0, 0, 2'd0, 8'b0001_0000, 0, 0, 0); want[1] = 8'h40;
        its[2] = mk(0, 0, 2'd0, 8'b0011_0000, 0, 0, 0); want[2] = ROUND ? 8'h42 : 8'h41;
        its[3] = mk(0, 0, 2'd0, 8'b0001_0000, 1, 0, 0); want[3] = ROUND ? 8'h41 : 8'h40;
        for (int i = 0; i < 4; i++) begin
            run_one(its[i], p, lat);
            checks++;
            if (p !== want[i]) begin errors++; $display("FAIL round[%0d] got %h want %h", i, p, want[i]); end
        end
    endtask

    task automatic test_specials();
        item_t      its[4];
        logic [7:0] want[4];
        logic [7:0] p;
        int         lat;
        its[0] = mk(0, 0, 2'd0, 8'b0001_1000, 1, 1, 1);  want[0] = 8'h80;
        its[1] = mk(0, 0, 2'd0, 8'b0001_1000, 1, 1, 0);  want[1] = 8'h00;
        its[2] = mk(1, 6, 2'd3, 8'hFF, 1, 0, 1);         want[2] = 8'h80;
        its[3] = mk(1, -7, 2'd1, 8'h18, 1, 1, 0);        want[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            run_one(its[i], p, lat);
            checks++;
            if (p !== want[i]) begin errors++; $display("FAIL special[%0d] got %h want %h", i, p, want[i]); end
        end
    endtask

    // Streams n items; toggle=1 flips rdy_i every 2 cycles with no input
    // gaps, toggle=0 uses random rdy_i and random input gaps.
    task automatic test_back_to_back(input int n, input bit toggle);
        logic [7:0] q[$];
        logic [7:0] held = '0;
        logic [7:0] want;
        item_t      cur;
        bit         have = 0, stalled = 0, exp_rdy;
        int         sent = 0, rcvd = 0, occ = 0, cyc = 0;
        while (rcvd < n && cyc < 3000) begin
            @(negedge clk_i);
            rdy_i = toggle ? ((cyc / 2) % 2 == 0) : (($urandom % 4) != 0);
            if (!have && sent < n && (toggle || ($urandom % 4) != 0)) begin
                cur  = rand_item();
                have = 1;
            end
            drive(cur);
            vld_i = have;
            #1;
            if (stalled) begin
                checks++;
                if (vld_o !== 1'b1 || pout !== held) begin
                    errors++;
                    $display("FAIL stall_hold got vld=%b pout=%h want vld=1 pout=%h", vld_o, pout, held);
                end
            end
            exp_rdy = (occ < 2) || rdy_i;
            checks++;
            if (rdy_o !== exp_rdy) begin errors++; $display("FAIL rdy_o cyc %0d got %b want %b", cyc, rdy_o, exp_rdy); end
            if (vld_o === 1'b1 && rdy_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got %h want no output", pout);
                end else begin
                    want = q.pop_front();
                    if (pout !== want) begin errors++; $display("FAIL stream[%0d] got %h want %h", rcvd, pout, want); end
                end
                rcvd++;
                occ--;
            end
            if (vld_i && rdy_o === 1'b1) begin
                q.push_back(model(cur));
                sent++;
                occ++;
                have = 0;
            end
            stalled = (vld_o === 1'b1) && !rdy_i;
            held    = pout;
            cyc++;
        end
        checks++;
        if (rcvd !== n) begin errors++; $display("FAIL stream_count got %0d want %0d", rcvd, n); end
        @(negedge clk_i);
        vld_i = 1'b0;
        rdy_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            checks++;
            if (vld_o !== 1'b0) begin errors++; $display("FAIL stream_dup got vld_o=%b want 0", vld_o); end
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk_i);
        rdy_i = 1'b0;
        drive(mk(0, 0, 2'd0, 8'h80, 0, 0, 0));
        vld_i = 1'b1;
        @(negedge clk_i);
        drive(mk(1, 2, 2'd1, 8'h55, 0, 0, 0));
        @(negedge clk_i);
        vld_i = 1'b0;
        checks++;
        if (vld_o !== 1'b1) begin errors++; $display("FAIL inflight_vld got %b want 1", vld_o); end
        checks++;
        if (rdy_o !== 1'b0) begin errors++; $display("FAIL inflight_full_rdy got %b want 0", rdy_o); end
        rst = 1'b1;
        @(negedge clk_i);
        checks++;
        if (vld_o !== 1'b0) begin errors++; $display("FAIL rst_flight_vld got %b want 0", vld_o); end
        checks++;
        if (pout !== 8'h00) begin errors++; $display("FAIL rst_flight_pout got %h want 00", pout); end
        checks++;
        if (rdy_o !== 1'b1) begin errors++; $display("FAIL rst_flight_rdy got %b want 1", rdy_o); end
        rst = 1'b0;
        rdy_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            checks++;
            if (vld_o !== 1'b0) begin errors++; $display("FAIL rst_stale got vld_o=%b want 0", vld_o); end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_clamp();
        test_round();
        test_specials();
        test_back_to_back(6, 1'b1);
        test_back_to_back(60, 1'b0);
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
